// File: rtl/axis_elastic_buffer.sv
// AXI-Stream elastic buffer: DEPTH-entry circular store with registered tready/tvalid,
// optional tlast/tkeep/tuser sideband and fill-level / almost-full status.
module axis_elastic_buffer #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned TLAST_ENABLE = 1,
  parameter int unsigned KEEP_ENABLE  = 0,
  parameter int unsigned USER_WIDTH   = 1,
  parameter int unsigned USER_ENABLE  = 0,
  parameter int unsigned ALMOST_FULL  = DEPTH - 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready,
  input  logic [DATA_WIDTH-1:0]        s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0]      s_axis_tkeep,
  input  logic                         s_axis_tlast,
  input  logic [USER_WIDTH-1:0]        s_axis_tuser,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic [DATA_WIDTH-1:0]        m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0]      m_axis_tkeep,
  output logic                         m_axis_tlast,
  output logic [USER_WIDTH-1:0]        m_axis_tuser,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         almost_full
);

  localparam int unsigned KEEP_W = DATA_WIDTH / 8;
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned LVL_W  = $clog2(DEPTH + 1);

  // Elaboration-time parameter sanity checks
  if (DEPTH < 2) begin : g_bad_depth
    $error("axis_elastic_buffer: DEPTH must be >= 2");
  end
  if (ALMOST_FULL < 1 || ALMOST_FULL > DEPTH) begin : g_bad_af
    $error("axis_elastic_buffer: ALMOST_FULL must be in 1..DEPTH");
  end
  if (USER_WIDTH < 1) begin : g_bad_user
    $error("axis_elastic_buffer: USER_WIDTH must be >= 1");
  end
  if (KEEP_ENABLE != 0 && (DATA_WIDTH % 8) != 0) begin : g_bad_keep
    $error("axis_elastic_buffer: DATA_WIDTH must be a multiple of 8 with KEEP_ENABLE");
  end

  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] rd_ptr_d;
  logic [LVL_W-1:0] level_q;
  logic [LVL_W-1:0] level_d;
  logic             tready_q;
  logic             tvalid_q;
  logic             almost_full_q;
  logic             push;
  logic             pop;

  // Handshakes, wrapping pointer advance and next fill level
  always_comb begin
    push     = s_axis_tvalid & tready_q;
    pop      = tvalid_q & m_axis_tready;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    level_d = level_q + LVL_W'(push) - LVL_W'(pop);
  end

  // Control state; ready/valid are derived from the next level so neither
  // depends combinationally on the opposite side of the handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      tready_q      <= 1'b0;
      tvalid_q      <= 1'b0;
      almost_full_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      tready_q      <= (level_d != LVL_W'(DEPTH));
      tvalid_q      <= (level_d != '0);
      almost_full_q <= (level_d >= LVL_W'(ALMOST_FULL));
    end
  end

  assign s_axis_tready = tready_q;
  assign m_axis_tvalid = tvalid_q;
  assign level         = level_q;
  assign almost_full   = almost_full_q;

  // Payload storage; entries need no reset since tvalid gates their use
  logic [DATA_WIDTH-1:0] data_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      data_mem[wr_ptr_q] <= s_axis_tdata;
    end
  end

  assign m_axis_tdata = data_mem[rd_ptr_q];

  if (TLAST_ENABLE != 0) begin : g_last
    logic last_mem [DEPTH];
    always_ff @(posedge clk) begin
      if (push && !rst) begin
        last_mem[wr_ptr_q] <= s_axis_tlast;
      end
    end
    assign m_axis_tlast = last_mem[rd_ptr_q];
  end else begin : g_no_last
    logic unused_last;
    assign unused_last  = s_axis_tlast;
    assign m_axis_tlast = 1'b0;
  end

  if (KEEP_ENABLE != 0) begin : g_keep
    logic [KEEP_W-1:0] keep_mem [DEPTH];
    always_ff @(posedge clk) begin
      if (push && !rst) begin
        keep_mem[wr_ptr_q] <= s_axis_tkeep;
      end
    end
    assign m_axis_tkeep = keep_mem[rd_ptr_q];
  end else begin : g_no_keep
    logic unused_keep;
    assign unused_keep  = ^s_axis_tkeep;
    assign m_axis_tkeep = '1;
  end

  if (USER_ENABLE != 0) begin : g_user
    logic [USER_WIDTH-1:0] user_mem [DEPTH];
    always_ff @(posedge clk) begin
      if (push && !rst) begin
        user_mem[wr_ptr_q] <= s_axis_tuser;
      end
    end
    assign m_axis_tuser = user_mem[rd_ptr_q];
  end else begin : g_no_user
    logic unused_user;
    assign unused_user  = ^s_axis_tuser;
    assign m_axis_tuser = '0;
  end

endmodule

// File: tb/tb_axis_elastic_buffer.sv
// Bench for axis_elastic_buffer: three configurations (DEPTH 2, 4, 3) checked against
// queue-based reference models of the buffer's occupancy and FIFO ordering.
module tb_axis_elastic_buffer;

  logic clk = 1'b0;
  logic rst;
  int   total;
  int   bad;

  always #5 clk = ~clk;

  // DEPTH=2, default sideband (tlast on, keep/user off)
  logic       s2_valid, s2_ready, s2_last, m2_valid, m2_ready, m2_last, af2;
  logic [7:0] s2_data, m2_data;
  logic [0:0] s2_keep, m2_keep, s2_user, m2_user;
  logic [1:0] lvl2;

  // DEPTH=4, ALMOST_FULL=3, tlast disabled
  logic       s4_valid, s4_ready, s4_last, m4_valid, m4_ready, m4_last, af4;
  logic [7:0] s4_data, m4_data;
  logic [0:0] s4_keep, m4_keep, s4_user, m4_user;
  logic [2:0] lvl4;

  // DEPTH=3, 16-bit data with keep and 4-bit user
  logic        s3_valid, s3_ready, s3_last, m3_valid, m3_ready, m3_last, af3;
  logic [15:0] s3_data, m3_data;
  logic [1:0]  s3_keep, m3_keep;
  logic [3:0]  s3_user, m3_user;
  logic [1:0]  lvl3;

  axis_elastic_buffer #(.DATA_WIDTH(8), .DEPTH(2)) dut2 (
    .clk(clk), .rst(rst),
    .s_axis_tvalid(s2_valid), .s_axis_tready(s2_ready), .s_axis_tdata(s2_data),
    .s_axis_tkeep(s2_keep), .s_axis_tlast(s2_last), .s_axis_tuser(s2_user),
    .m_axis_tvalid(m2_valid), .m_axis_tready(m2_ready), .m_axis_tdata(m2_data),
    .m_axis_tkeep(m2_keep), .m_axis_tlast(m2_last), .m_axis_tuser(m2_user),
    .level(lvl2), .almost_full(af2)
  );

  axis_elastic_buffer #(.DATA_WIDTH(8), .DEPTH(4), .TLAST_ENABLE(0), .ALMOST_FULL(3)) dut4 (
    .clk(clk), .rst(rst),
    .s_axis_tvalid(s4_valid), .s_axis_tready(s4_ready), .s_axis_tdata(s4_data),
    .s_axis_tkeep(s4_keep), .s_axis_tlast(s4_last), .s_axis_tuser(s4_user),
    .m_axis_tvalid(m4_valid), .m_axis_tready(m4_ready), .m_axis_tdata(m4_data),
    .m_axis_tkeep(m4_keep), .m_axis_tlast(m4_last), .m_axis_tuser(m4_user),
    .level(lvl4), .almost_full(af4)
  );

  axis_elastic_buffer #(.DATA_WIDTH(16), .DEPTH(3), .KEEP_ENABLE(1), .USER_WIDTH(4),
                        .USER_ENABLE(1)) dut3 (
    .clk(clk), .rst(rst),
    .s_axis_tvalid(s3_valid), .s_axis_tready(s3_ready), .s_axis_tdata(s3_data),
    .s_axis_tkeep(s3_keep), .s_axis_tlast(s3_last), .s_axis_tuser(s3_user),
    .m_axis_tvalid(m3_valid), .m_axis_tready(m3_ready), .m_axis_tdata(m3_data),
    .m_axis_tkeep(m3_keep), .m_axis_tlast(m3_last), .m_axis_tuser(m3_user),
    .level(lvl3), .almost_full(af3)
  );

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    s2_valid = 1'b1; s4_valid = 1'b1; s3_valid = 1'b1;
    m2_ready = 1'b0; m4_ready = 1'b0; m3_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      total++;
      if ({s2_ready, m2_valid, lvl2, af2} !== 5'b0) begin
        bad++; $display("FAIL reset_hold_d2 got=%b exp=%b", {s2_ready, m2_valid, lvl2, af2}, 5'b0);
      end
      total++;
      if ({s4_ready, m4_valid, lvl4, af4} !== 6'b0) begin
        bad++; $display("FAIL reset_hold_d4 got=%b exp=%b", {s4_ready, m4_valid, lvl4, af4}, 6'b0);
      end
      total++;
      if ({s3_ready, m3_valid, lvl3, af3} !== 5'b0) begin
        bad++; $display("FAIL reset_hold_d3 got=%b exp=%b", {s3_ready, m3_valid, lvl3, af3}, 5'b0);
      end
    end
    rst = 1'b0;
    s2_valid = 1'b0; s4_valid = 1'b0; s3_valid = 1'b0;
    @(negedge clk);
    total++;
    if ({s2_ready, m2_valid, lvl2} !== 4'b1000) begin
      bad++; $display("FAIL reset_release_d2 got=%b exp=%b", {s2_ready, m2_valid, lvl2}, 4'b1000);
    end
    total++;
    if ({s4_ready, m4_valid, lvl4} !== 5'b10000) begin
      bad++; $display("FAIL reset_release_d4 got=%b exp=%b", {s4_ready, m4_valid, lvl4}, 5'b10000);
    end
    total++;
    if ({s3_ready, m3_valid, lvl3} !== 4'b1000) begin
      bad++; $display("FAIL reset_release_d3 got=%b exp=%b", {s3_ready, m3_valid, lvl3}, 4'b1000);
    end
  endtask

  task automatic test_streaming();
    logic [7:0] q[$];
    int  sent, got, cyc, first_acc, first_pop, last_pop;
    bit  push, pop;
    sent = 0; got = 0; cyc = 0; first_acc = -1; first_pop = -1; last_pop = -1;
    m2_ready = 1'b1;
    s2_valid = 1'b1;
    s2_data  = 8'h01;
    while (got < 16 && cyc < 100) begin
      push = s2_valid && (q.size() != 2);
      pop  = (q.size() != 0) && m2_ready;
      @(negedge clk);
      cyc++;
      if (pop) begin
        void'(q.pop_front());
        got++;
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
      end
      if (push) begin
        q.push_back(s2_data);
        sent++;
        if (first_acc < 0) first_acc = cyc;
      end
      total++;
      if ({s2_ready, m2_valid, lvl2} !== {q.size() != 2, q.size() != 0, 2'(q.size())}) begin
        bad++;
        $display("FAIL stream_status cyc=%0d got=%b exp=%b", cyc, {s2_ready, m2_valid, lvl2},
                 {q.size() != 2, q.size() != 0, 2'(q.size())});
      end
      if (q.size() != 0) begin
        total++;
        if ({m2_data, m2_keep, m2_user} !== {8'(got + 1), 1'b1, 1'b0}) begin
          bad++;
          $display("FAIL stream_payload cyc=%0d got=%h exp=%h", cyc, {m2_data, m2_keep, m2_user},
                   {8'(got + 1), 1'b1, 1'b0});
        end
      end
      total++;
      if (lvl2 > 2'd1) begin
        bad++; $display("FAIL stream_level_max cyc=%0d got=%0d exp<=1", cyc, lvl2);
      end
      s2_valid = (sent < 16);
      s2_data  = 8'(sent + 1);
    end
    total++;
    if (got != 16) begin
      bad++; $display("FAIL stream_count got=%0d exp=16", got);
    end
    total++;
    if (first_pop != first_acc + 1) begin
      bad++; $display("FAIL stream_latency got=%0d exp=%0d", first_pop, first_acc + 1);
    end
    total++;
    if (last_pop - first_pop != 15) begin
      bad++; $display("FAIL stream_throughput got=%0d exp=15", last_pop - first_pop);
    end
    s2_valid = 1'b0;
    m2_ready = 1'b0;
  endtask

  task automatic test_fill_stall();
    logic [7:0] q[$];
    int  sent, got, cyc;
    bit  push, pop;
    sent = 0; got = 0; cyc = 0;
    m4_ready = 1'b0;
    s4_valid = 1'b1;
    s4_data  = 8'h40;
    s4_last  = 1'b1;
    while (got < 6 && cyc < 60) begin
      push = s4_valid && (q.size() != 4);
      pop  = (q.size() != 0) && m4_ready;
      @(negedge clk);
      cyc++;
      if (pop) begin
        void'(q.pop_front());
        got++;
      end
      if (push) begin
        q.push_back(s4_data);
        sent++;
      end
      total++;
      if ({s4_ready, m4_valid, lvl4, af4} !==
          {q.size() != 4, q.size() != 0, 3'(q.size()), q.size() >= 3}) begin
        bad++;
        $display("FAIL fill_status cyc=%0d got=%b exp=%b", cyc, {s4_ready, m4_valid, lvl4, af4},
                 {q.size() != 4, q.size() != 0, 3'(q.size()), q.size() >= 3});
      end
      if (q.size() != 0) begin
        total++;
        if ({m4_data, m4_last} !== {8'(8'h40 + got), 1'b0}) begin
          bad++;
          $display("FAIL fill_payload cyc=%0d got=%h exp=%h", cyc, {m4_data, m4_last},
                   {8'(8'h40 + got), 1'b0});
        end
      end
      if (cyc == 6) begin
        total++;
        if ({s4_ready, m4_valid, lvl4, af4} !== {1'b0, 1'b1, 3'd4, 1'b1}) begin
          bad++;
          $display("FAIL fill_full got=%b exp=%b", {s4_ready, m4_valid, lvl4, af4},
                   {1'b0, 1'b1, 3'd4, 1'b1});
        end
      end
      if (pop && got == 1) begin
        total++;
        if (s4_ready !== 1'b1) begin
          bad++; $display("FAIL fill_ready_after_pop got=%b exp=1", s4_ready);
        end
      end
      m4_ready = (cyc >= 6);
      s4_valid = (sent < 6);
      s4_data  = 8'(8'h40 + sent);
    end
    total++;
    if (got != 6) begin
      bad++; $display("FAIL fill_count got=%0d exp=6", got);
    end
    s4_valid = 1'b0;
  endtask

  task automatic test_wrap();
    logic [22:0] q[$];
    int  sent, got, cyc;
    bit  push, pop;
    sent = 0; got = 0; cyc = 0;
    s3_valid = 1'b0;
    m3_ready = 1'b0;
    while (got < 1000 && cyc < 20000) begin
      push = s3_valid && (q.size() != 3);
      pop  = (q.size() != 0) && m3_ready;
      @(negedge clk);
      cyc++;
      if (pop) begin
        void'(q.pop_front());
        got++;
      end
      if (push) begin
        q.push_back({s3_data, s3_keep, s3_last, s3_user});
        sent++;
      end
      total++;
      if ({s3_ready, m3_valid, lvl3, af3} !==
          {q.size() != 3, q.size() != 0, 2'(q.size()), q.size() >= 2}) begin
        bad++;
        $display("FAIL wrap_status cyc=%0d got=%b exp=%b", cyc, {s3_ready, m3_valid, lvl3, af3},
                 {q.size() != 3, q.size() != 0, 2'(q.size()), q.size() >= 2});
      end
      if (q.size() != 0) begin
        total++;
        if ({m3_data, m3_keep, m3_last, m3_user} !== q[0]) begin
          bad++;
          $display("FAIL wrap_payload cyc=%0d got=%h exp=%h", cyc,
                   {m3_data, m3_keep, m3_last, m3_user}, q[0]);
        end
      end
      if (!s3_valid || push) begin
        if (sent < 1000 && ($urandom % 2) == 1) begin
          s3_valid = 1'b1;
          s3_data  = 16'($urandom);
          s3_keep  = 2'($urandom);
          s3_user  = 4'($urandom);
          s3_last  = ((sent % 7) == 6);
        end else begin
          s3_valid = 1'b0;
        end
      end
      m3_ready = 1'($urandom);
    end
    total++;
    if (got != 1000) begin
      bad++; $display("FAIL wrap_count got=%0d exp=1000", got);
    end
    s3_valid = 1'b0;
    m3_ready = 1'b0;
  endtask

  task automatic test_mid_reset();
    m4_ready = 1'b0;
    s4_valid = 1'b1;
    s4_data  = 8'h31;
    @(negedge clk);
    s4_data = 8'h32;
    @(negedge clk);
    s4_data = 8'h33;
    @(negedge clk);
    s4_valid = 1'b0;
    total++;
    if ({m4_valid, lvl4, m4_data} !== {1'b1, 3'd3, 8'h31}) begin
      bad++; $display("FAIL midrst_preload got=%h exp=%h", {m4_valid, lvl4, m4_data}, {1'b1, 3'd3, 8'h31});
    end
    rst      = 1'b1;
    s4_valid = 1'b1;
    s4_data  = 8'h99;
    @(negedge clk);
    rst      = 1'b0;
    s4_valid = 1'b0;
    m4_ready = 1'b1;
    total++;
    if ({s4_ready, m4_valid, lvl4, af4} !== 6'b0) begin
      bad++; $display("FAIL midrst_in_reset got=%b exp=%b", {s4_ready, m4_valid, lvl4, af4}, 6'b0);
    end
    repeat (2) begin
      @(negedge clk);
      total++;
      if ({s4_ready, m4_valid, lvl4, af4} !== 6'b100000) begin
        bad++; $display("FAIL midrst_after got=%b exp=%b", {s4_ready, m4_valid, lvl4, af4}, 6'b100000);
      end
    end
    s4_valid = 1'b1;
    s4_data  = 8'hAA;
    @(negedge clk);
    s4_valid = 1'b0;
    total++;
    if ({m4_valid, lvl4, m4_data} !== {1'b1, 3'd1, 8'hAA}) begin
      bad++; $display("FAIL midrst_first_beat got=%h exp=%h", {m4_valid, lvl4, m4_data}, {1'b1, 3'd1, 8'hAA});
    end
    @(negedge clk);
    total++;
    if ({m4_valid, lvl4} !== 4'b0000) begin
      bad++; $display("FAIL midrst_drained got=%b exp=%b", {m4_valid, lvl4}, 4'b0000);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    s2_valid = 1'b0; s2_data = '0; s2_keep = '0; s2_last = 1'b0; s2_user = '0; m2_ready = 1'b0;
    s4_valid = 1'b0; s4_data = '0; s4_keep = '0; s4_last = 1'b0; s4_user = '1; m4_ready = 1'b0;
    s3_valid = 1'b0; s3_data = '0; s3_keep = '0; s3_last = 1'b0; s3_user = '0; m3_ready = 1'b0;
    test_reset();
    test_streaming();
    test_fill_stall();
    test_wrap();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
